// File: rtl/hw_demux_buf.sv
// Registered 1-to-4 demultiplexer: one producer feeds four single-entry lane buffers,
// each drained by its own valid/ack consumer. Also keeps an accept counter and a sticky error flag.
module hw_demux_buf #(
    parameter int DW = 3,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   din,
    input  logic [1:0]      sel,
    input  logic            din_vld,
    output logic            din_rdy,
    output logic [4*DW-1:0] dout,
    output logic [3:0]      vld,
    input  logic [3:0]      ack,
    output logic [CW-1:0]   xfer_cnt,
    output logic            ack_err
);

    logic [DW-1:0] data_q [4];
    logic [DW-1:0] data_d [4];
    logic [3:0]    vld_q, vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          accept;

    // A lane can take a new word when it is empty or is being drained this cycle.
    assign din_rdy = ~vld_q[sel] | ack[sel];
    assign accept  = din_vld & din_rdy;

    always_comb begin
        vld_d = vld_q;
        cnt_d = cnt_q;
        err_d = err_q | (|(ack & ~vld_q));
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
            if (accept && (sel == 2'(i))) begin
                data_d[i] = din;
                vld_d[i]  = 1'b1;
            end else if (ack[i]) begin
                vld_d[i]  = 1'b0;
            end
        end
        if (accept) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign dout[g*DW +: DW] = data_q[g];
    end

    assign vld      = vld_q;
    assign xfer_cnt = cnt_q;
    assign ack_err  = err_q;

endmodule
